rc_pulse_capture: RTL
=====================

# rc_pulse_capture

Upstream stage of the servo/ESC PWM generator. Measures the high time of a hobby-RC pulse stream (1–2 ms pulses, ~50 Hz) on an asynchronous input pin. Converts it into a clamped duty value in 12 MHz clock counts, the same units as the generator's duty compare register. Falls back to a failsafe value when the stream stops or goes invalid.

## Interface

Parameters:
- WIDTH, 19, bit width of counters and `duty` (matches the 50 Hz generator duty register)
- MIN_CNT, 12000, lower clamp (1.0 ms at 12 MHz)
- MAX_CNT, 24000, upper clamp (2.0 ms)
- REJECT_LO, 6000, pulses shorter than this (0.5 ms) are glitches and are discarded
- REJECT_HI, 30000, pulses longer than this (2.5 ms) are invalid and are discarded
- FAILSAFE_CNT, 18000, neutral value (1.5 ms) driven at reset and on signal loss
- TIMEOUT_CNT, 300000, cycles (25 ms) without an accepted pulse before signal loss

Ports:
- clk  in  1  system clock, 12 MHz
- rst_n  in  1  asynchronous, active-low reset
- pwm_in  in  1  raw RC pulse input, asynchronous to clk
- duty  out  WIDTH  latest accepted, clamped pulse width in clk counts
- duty_valid  out  1  one-cycle strobe whenever `duty` is (re)written
- signal_lost  out  1  high while no accepted pulse has occurred within TIMEOUT_CNT

## Operation

- Input passes through a 2-FF synchronizer followed by a registered edge detector, which produces `rise` and `fall`.
- FSM states:
  - WAIT_RISE: `rise` → HIGH, width counter loaded with 1.
  - HIGH: counter increments each cycle while the synced input is high.
    - `fall` → width evaluated, go to WAIT_RISE.
    - Counter exceeding REJECT_HI → STUCK.
  - STUCK: ignore the input until `fall`, then go to WAIT_RISE. The pulse is discarded.
- Evaluation of measured width N:
  - N < REJECT_LO: discard.
  - REJECT_LO ≤ N ≤ REJECT_HI: accept.
    - `duty` = clamp(N, MIN_CNT, MAX_CNT).
    - `duty_valid` pulses.
    - Timeout timer clears.
    - `signal_lost` deasserts.
- Timeout timer:
  - Increments every cycle and saturates at TIMEOUT_CNT.
  - Clears only on an accepted pulse.
  - On reaching TIMEOUT_CNT while `signal_lost`=0: `signal_lost`=1, `duty`=FAILSAFE_CNT, one `duty_valid` strobe. Further strobes occur only after recovery.
- Width counter saturates at REJECT_HI+1 and never wraps.
- Accept and timeout in the same cycle: accept wins and the timer clears.
- A discarded pulse never changes `duty` or the timer.

## Timing

- Reset values: `duty`=FAILSAFE_CNT, `duty_valid`=0, `signal_lost`=1, FSM=WAIT_RISE, all counters 0, synchronizer flops 0.
- Reset is asynchronous and takes effect mid-pulse. After release, a pulse already in progress is not measured; the first `rise` seen after release starts the measurement.
- Measured N equals the number of rising clk edges that sample `pwm_in` high, exact for a clean input. The synchronizer delay cancels between the two edges.
- Latency: `duty`/`duty_valid` update 3 clk cycles after the first clk edge that samples `pwm_in` low (2 sync stages plus 1 register).
- `duty_valid` is high for exactly one cycle. `duty` holds its value between strobes.
- Recovery after loss takes a single accepted pulse.

## Structure

- Shared package `rc_pkg`: default constants MIN_CNT, MAX_CNT, REJECT_LO, REJECT_HI, FAILSAFE_CNT, TIMEOUT_CNT, WIDTH, and the FSM state enum (WAIT_RISE, HIGH, STUCK). The PWM generator reuses WIDTH and the clamp limits.
- One sub-module, `sync_edge`: 2-FF synchronizer plus edge detect, with outputs `level`, `rise`, `fall` and async active-low reset. The FSM, timer, and clamp live in the top module.

## Test plan

- Reset, then 1.5 ms pulses every 20 ms: first strobe gives `duty`=18000 and `signal_lost`=0 three cycles after the falling edge.
- Pulses of 0.8 ms and 2.3 ms: `duty`=12000 and 24000 respectively (clamped), one strobe each.
- 0.2 ms glitch and a 3.0 ms pulse between valid 1.2 ms pulses: no strobe for either, `duty` stays 14400, FSM returns to WAIT_RISE after the long pulse falls.
- Stop the stream after a 1.8 ms pulse: exactly 300000 cycles after the accept, `signal_lost`=1, `duty`=18000, one strobe. One 1.1 ms pulse then gives `duty`=13200 and `signal_lost`=0.
- Assert `rst_n` low mid-pulse: outputs are at reset values immediately. After release, the tail of the pulse is ignored and the next full 1.0 ms pulse gives `duty`=12000.
- Jittered edges (random asynchronous phase): measured `duty` is within ±1 count of the ideal value.

Source files
------------

// File: rtl/rc_pkg.sv
// Shared constants and types for the RC pulse capture front end and the PWM generator.
// All counts are in 12 MHz clock cycles.
package rc_pkg;

   localparam int unsigned WIDTH        = 19;
   localparam int unsigned MIN_CNT      = 12000;
   localparam int unsigned MAX_CNT      = 24000;
   localparam int unsigned REJECT_LO    = 6000;
   localparam int unsigned REJECT_HI    = 30000;
   localparam int unsigned FAILSAFE_CNT = 18000;
   localparam int unsigned TIMEOUT_CNT  = 300000;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      HIGH      = 2'd1,
      STUCK     = 2'd2
   } rc_state_t;

   function automatic int unsigned clamp_cnt(input int unsigned n,
                                             input int unsigned lo,
                                             input int unsigned hi);
      if (n < lo) return lo;
      if (n > hi) return hi;
      return n;
   endfunction

endpackage

// File: rtl/rc_pulse_capture_if.sv
// Pulse input and duty output bundle between the capture block and the PWM generator.
interface rc_pulse_capture_if #(
   parameter int unsigned WIDTH = rc_pkg::WIDTH
) ();

   logic             pwm_in;
   logic [WIDTH-1:0] duty;
   logic             duty_valid;
   logic             signal_lost;

   modport master (
      input  pwm_in,
      output duty,
      output duty_valid,
      output signal_lost
   );

   modport slave (
      output pwm_in,
      input  duty,
      input  duty_valid,
      input  signal_lost
   );

endinterface

// File: rtl/rc_pulse_capture_sync_edge.sv
// 2-FF synchronizer for the asynchronous RC input plus a registered edge detector.
// level, rise and fall are mutually aligned (all one register behind the second sync stage).
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic       s1;
   logic       s2;
   logic       s3;
   logic [2:0] fill;

   // Edges are suppressed until the chain holds only post-reset samples, so a pulse
   // already high at reset release yields no rise and its tail is never measured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s3   <= 1'b0;
         fill <= '0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         s3   <= s2;
         fill <= {fill[1:0], 1'b1};
         rise <= fill[2] &  s2 & ~s3;
         fall <= fill[2] & ~s2 &  s3;
      end
   end

   assign level = s3;

endmodule

// File: rtl/rc_pulse_capture.sv
// RC pulse width capture: measures high time, rejects glitches/overlong pulses,
// clamps to the servo range and falls back to a failsafe duty on signal loss.
module rc_pulse_capture
   import rc_pkg::*;
#(
   parameter int unsigned WIDTH        = rc_pkg::WIDTH,
   parameter int unsigned MIN_CNT      = rc_pkg::MIN_CNT,
   parameter int unsigned MAX_CNT      = rc_pkg::MAX_CNT,
   parameter int unsigned REJECT_LO    = rc_pkg::REJECT_LO,
   parameter int unsigned REJECT_HI    = rc_pkg::REJECT_HI,
   parameter int unsigned FAILSAFE_CNT = rc_pkg::FAILSAFE_CNT,
   parameter int unsigned TIMEOUT_CNT  = rc_pkg::TIMEOUT_CNT
) (
   input  logic               clk,
   input  logic               rst_n,
   rc_pulse_capture_if.master bus
);

   localparam logic [WIDTH-1:0] LO_W  = WIDTH'(REJECT_LO);
   localparam logic [WIDTH-1:0] HI_W  = WIDTH'(REJECT_HI);
   localparam logic [WIDTH-1:0] SAT_W = WIDTH'(REJECT_HI + 1);
   localparam logic [WIDTH-1:0] TO_W  = WIDTH'(TIMEOUT_CNT);
   localparam logic [WIDTH-1:0] FS_W  = WIDTH'(FAILSAFE_CNT);
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

   rc_state_t        state;
   logic [WIDTH-1:0] width_cnt;
   logic [WIDTH-1:0] tmr;
   logic [WIDTH-1:0] tmr_nxt;
   logic [WIDTH-1:0] duty_q;
   logic [WIDTH-1:0] duty_clamped;
   logic             valid_q;
   logic             lost_q;
   logic             accept;
   logic             level;
   logic             rise;
   logic             fall;

   sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (bus.pwm_in),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   always_comb begin
      tmr_nxt      = (tmr == TO_W) ? tmr : tmr + ONE_W;
      accept       = (state == HIGH) && fall && (width_cnt >= LO_W) && (width_cnt <= HI_W);
      duty_clamped = WIDTH'(clamp_cnt(32'(width_cnt), MIN_CNT, MAX_CNT));
   end

   // Timeout is evaluated first so that a same-cycle accept overrides it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= WAIT_RISE;
         width_cnt <= '0;
         tmr       <= '0;
         duty_q    <= FS_W;
         valid_q   <= 1'b0;
         lost_q    <= 1'b1;
      end else begin
         valid_q <= 1'b0;
         tmr     <= tmr_nxt;

         if ((tmr_nxt == TO_W) && !lost_q) begin
            lost_q  <= 1'b1;
            duty_q  <= FS_W;
            valid_q <= 1'b1;
         end

         case (state)
            WAIT_RISE: begin
               if (rise) begin
                  width_cnt <= ONE_W;
                  state     <= HIGH;
               end
            end
            HIGH: begin
               if (fall) begin
                  state <= WAIT_RISE;
                  if (accept) begin
                     duty_q  <= duty_clamped;
                     valid_q <= 1'b1;
                     lost_q  <= 1'b0;
                     tmr     <= '0;
                  end
               end else if (width_cnt > HI_W) begin
                  state <= STUCK;
               end else if (level && (width_cnt != SAT_W)) begin
                  width_cnt <= width_cnt + ONE_W;
               end
            end
            STUCK: begin
               if (fall) state <= WAIT_RISE;
            end
            default: state <= WAIT_RISE;
         endcase
      end
   end

   assign bus.duty        = duty_q;
   assign bus.duty_valid  = valid_q;
   assign bus.signal_lost = lost_q;

endmodule
